code_value_ram_banked: RTL and testbench
========================================

// Module: code_value_ram_banked
// PURPOSE
//  Parametrised, banked, true dual-port code-value store for the LZW engine (next generation of
//  the 4-bank code value RAM). Both ports read and write. A built-in init engine loads the
//  dictionary seed (entry i = i for i < INIT_CODES, FILL_VAL above that) at BANKS entries per cycle.
//  Port A serves the dictionary lookup path. Port B serves string update/trace-back.
// PARAMETERS
//  DATA_W     13      code value width
//  ADDR_W     12      word address width; depth = 2**ADDR_W
//  BANKS      4       bank count, power of 2, 1..16; bank = addr[BSEL_W-1:0], row = addr[ADDR_W-1:BSEL_W]
//  INIT_CODES 256     entries seeded with their own index (must be <= depth)
//  FILL_VAL   all-1s  seed for entries >= INIT_CODES (DATA_W wide)
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  init_start  in   1       one-cycle pulse: start seeding the whole array
//  init_busy   out  1       seeding in progress; user accesses are dropped
//  init_done   out  1       high from seed completion until next init_start or reset
//  en_a/en_b   in   1       port access request
//  we_a/we_b   in   1       1 = write, 0 = read (qualified by en_x)
//  addr_a/b    in   ADDR_W  word address
//  wdata_a/b   in   DATA_W  write data
//  rdata_a/b   out  DATA_W  read data, held between reads
//  rvalid_a/b  out  1       one-cycle pulse: rdata_x updated this cycle
//  collision   out  1       one-cycle pulse: same-cycle write from both ports to same address
// BEHAVIOUR
//  Reset: init_busy, init_done, rvalid_a/b, collision = 0. rdata_a/b = 0. FSM to IDLE.
//   Array contents are not reset.
//  FSM IDLE -> SEED on init_start (ignored while in SEED). SEED: row counter 0..depth/BANKS-1;
//   each cycle all banks write the row; data = index<INIT_CODES ? index : FILL_VAL,
//   where index = row*BANKS+bank. Last row -> DONE. DONE -> SEED on init_start.
//  init_busy is high in SEED. The first seed write is the cycle after init_start.
//   Seeding takes exactly depth/BANKS cycles. init_done rises the cycle after the last row write.
//  User access in the init_start cycle completes normally. From the next cycle until init_busy
//   falls, all en_a/en_b requests are dropped: no write, no rvalid.
//  Read latency 1: en_x & ~we_x in cycle N -> rdata_x/rvalid_x in cycle N+1.
//   rdata_x holds its value when no read completes.
//  Output mux uses registered bank select (bank of cycle-N address). The address may change in N+1.
//  Same-port read vs. write needs no rule (one op per port per cycle).
//  Cross-port read of an address written by the other port in the same cycle returns the OLD data.
//   A read of that address one cycle later returns the new data.
//  Both ports write the same address in the same cycle: port B data is stored. collision pulses N+1.
//  Both ports access different addresses in the same bank: both complete (true dual-port bank).
//  Address wrap: none. Any ADDR_W value is legal.
//  Reset mid-SEED aborts: init_busy=0, init_done=0, array partially seeded/undefined.
// TESTING
//  1. Reset, init_start pulse -> init_busy high for 1024 cycles (defaults).
//     Reads then give addr 0x005->0x005, 0x0FF->0x0FF, 0x100->0x1FFF, 0xFFF->0x1FFF.
//  2. Write A addr 0x123=0x0ABC, next cycle read B 0x123 -> rvalid_b pulse, rdata_b=0x0ABC.
//     rdata_b holds over 5 idle cycles.
//  3. Same cycle: A writes 0x200=0x0111, B writes 0x200=0x0222 -> collision pulse.
//     Later read 0x200 = 0x0222.
//  4. Same cycle: A reads 0x301 (old 0x0301-seeded FILL), B writes 0x301=0x0042.
//     -> rdata_a = old value. Re-read next cycle gives 0x0042.
//  5. Back-to-back A reads 0x004,0x005,0x006,0x007 (all banks) -> rvalid_a every cycle with correct data.
//     Repeat with BANKS=1 and BANKS=8 builds.
//  6. Assert rst_n low at seed row 100, release, start again.
//     -> init_done=0 during reset; full 1024-cycle seed; all entries correct.
//     Requests issued during SEED produce no rvalid and no writes.

Source files
------------

// File: rtl/code_value_ram_banked.sv
// Banked true dual-port code-value store for the LZW engine, with a built-in
// seeding engine that writes one row across all banks per cycle.
module code_value_ram_banked #(
    parameter int                DATA_W     = 13,
    parameter int                ADDR_W     = 12,
    parameter int                BANKS      = 4,
    parameter int                INIT_CODES = 256,
    parameter logic [DATA_W-1:0] FILL_VAL   = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_start,
    output logic              init_busy,
    output logic              init_done,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b,
    output logic              collision
);

    localparam int BSEL_W = $clog2(BANKS);
    localparam int BW     = (BSEL_W > 0) ? BSEL_W : 1;
    localparam int ROW_W  = ADDR_W - BSEL_W;
    localparam int ROWS   = 1 << ROW_W;
    localparam logic [ADDR_W-1:0] BANK_MASK = ADDR_W'(BANKS - 1);
    localparam logic [ADDR_W:0]   INIT_LIM  = INIT_CODES[ADDR_W:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] seed_row_q, seed_row_d;

    function automatic logic [BW-1:0] bank_of(input logic [ADDR_W-1:0] a);
        return BW'(a & BANK_MASK);
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
        return ROW_W'(a >> BSEL_W);
    endfunction

    // Seed value of one entry: its own index below INIT_CODES, FILL_VAL above.
    function automatic logic [DATA_W-1:0] seed_val(input logic [ROW_W-1:0] row, input int b);
        logic [ADDR_W-1:0] idx;
        idx = (ADDR_W'(row) << BSEL_W) | ADDR_W'(b);
        return ({1'b0, idx} < INIT_LIM) ? DATA_W'(idx) : FILL_VAL;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            seed_row_q <= '0;
        end else begin
            state_q    <= state_d;
            seed_row_q <= seed_row_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        seed_row_d = seed_row_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (init_start) begin
                    state_d    = ST_SEED;
                    seed_row_d = '0;
                end
            end
            ST_SEED: begin
                seed_row_d = seed_row_q + 1'b1;
                if (seed_row_q == ROW_W'(ROWS - 1)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic seeding;
    assign seeding   = (state_q == ST_SEED);
    assign init_busy = seeding;
    assign init_done = (state_q == ST_DONE);

    // User requests are dropped for the whole seeding pass.
    logic rd_a, wr_a, rd_b, wr_b;
    assign rd_a = !seeding && en_a && !we_a;
    assign wr_a = !seeding && en_a && we_a;
    assign rd_b = !seeding && en_b && !we_b;
    assign wr_b = !seeding && en_b && we_b;

    logic [BW-1:0]    bank_a, bank_b;
    logic [ROW_W-1:0] row_a, row_b;
    assign bank_a = bank_of(addr_a);
    assign bank_b = bank_of(addr_b);
    assign row_a  = row_of(addr_a);
    assign row_b  = row_of(addr_b);

    logic [DATA_W-1:0] mem   [BANKS][ROWS];
    logic [DATA_W-1:0] brd_a [BANKS];
    logic [DATA_W-1:0] brd_b [BANKS];

    // Reads sample the array before this edge's writes land, so a cross-port
    // read of a just-written address returns the old data. Port B's write is
    // issued last and wins a same-address write collision.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            if (seeding) begin
                mem[b][seed_row_q] <= seed_val(seed_row_q, b);
            end else begin
                if (wr_a && bank_a == BW'(b)) mem[b][row_a] <= wdata_a;
                if (wr_b && bank_b == BW'(b)) mem[b][row_b] <= wdata_b;
            end
            if (rd_a && bank_a == BW'(b)) brd_a[b] <= mem[b][row_a];
            if (rd_b && bank_b == BW'(b)) brd_b[b] <= mem[b][row_b];
        end
    end

    logic [BW-1:0]     bsel_a_q, bsel_b_q;
    logic [DATA_W-1:0] hold_a_q, hold_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            bsel_a_q  <= '0;
            bsel_b_q  <= '0;
            hold_a_q  <= '0;
            hold_b_q  <= '0;
            collision <= 1'b0;
        end else begin
            rvalid_a  <= rd_a;
            rvalid_b  <= rd_b;
            if (rd_a) bsel_a_q <= bank_a;
            if (rd_b) bsel_b_q <= bank_b;
            hold_a_q  <= rdata_a;
            hold_b_q  <= rdata_b;
            collision <= wr_a && wr_b && (addr_a == addr_b);
        end
    end

    // Registered bank select lets the address move on while the data returns.
    assign rdata_a = rvalid_a ? brd_a[bsel_a_q] : hold_a_q;
    assign rdata_b = rvalid_b ? brd_b[bsel_b_q] : hold_b_q;

endmodule

// File: tb/tb_code_value_ram_banked.sv
// Bench for code_value_ram_banked: directed vector table, randomized traffic
// against an array reference model, and seed abort/restart sequences.
module tb_code_value_ram_banked;

    localparam int DATA_W     = 13;
    localparam int ADDR_W     = 12;
    localparam int BANKS      = 4;
    localparam int INIT_CODES = 256;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int SEED_CYC   = DEPTH / BANKS;
    localparam logic [DATA_W-1:0] FILL = '1;

    logic              clk, rst_n, init_start, init_busy, init_done;
    logic              en_a, we_a, en_b, we_b, rvalid_a, rvalid_b, collision;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b, rdata_a, rdata_b;

    code_value_ram_banked #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BANKS     (BANKS),
        .INIT_CODES(INIT_CODES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_start(init_start),
        .init_busy (init_busy),
        .init_done (init_done),
        .en_a      (en_a),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .wdata_a   (wdata_a),
        .rdata_a   (rdata_a),
        .rvalid_a  (rvalid_a),
        .en_b      (en_b),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .wdata_b   (wdata_b),
        .rdata_b   (rdata_b),
        .rvalid_b  (rvalid_b),
        .collision (collision)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int                n_vec = 0;
    int                n_err = 0;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                busy_left;
    logic              m_done, m_rv_a, m_rv_b, m_col;
    logic [DATA_W-1:0] m_rd_a, m_rd_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy_left = 0;
        m_done = 1'b0;
        m_rv_a = 1'b0;
        m_rv_b = 1'b0;
        m_col  = 1'b0;
        m_rd_a = '0;
        m_rd_b = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_busy"},     init_busy, busy_left > 0);
        check({tag, "_done"},     init_done, m_done);
        check({tag, "_rvalid_a"}, rvalid_a,  m_rv_a);
        check({tag, "_rdata_a"},  rdata_a,   m_rd_a);
        check({tag, "_rvalid_b"}, rvalid_b,  m_rv_b);
        check({tag, "_rdata_b"},  rdata_b,   m_rd_b);
        check({tag, "_collision"}, collision, m_col);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic st,
                        input logic ea, input logic wa,
                        input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] da,
                        input logic eb, input logic wb,
                        input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db);
        logic was_busy;
        init_start = st;
        en_a = ea; we_a = wa; addr_a = aa; wdata_a = da;
        en_b = eb; we_b = wb; addr_b = ab; wdata_b = db;
        was_busy = busy_left > 0;
        m_rv_a = !was_busy && ea && !wa;
        m_rv_b = !was_busy && eb && !wb;
        if (m_rv_a) m_rd_a = ref_mem[aa];
        if (m_rv_b) m_rd_b = ref_mem[ab];
        m_col = !was_busy && ea && wa && eb && wb && (aa == ab);
        if (!was_busy && ea && wa) ref_mem[aa] = da;
        if (!was_busy && eb && wb) ref_mem[ab] = db;
        if (was_busy) begin
            busy_left--;
            if (busy_left == 0) m_done = 1'b1;
        end else if (st) begin
            busy_left = SEED_CYC;
            m_done = 1'b0;
            for (int i = 0; i < DEPTH; i++)
                ref_mem[i] = (i < INIT_CODES) ? DATA_W'(i) : FILL;
        end
        @(posedge clk);
        #1;
        check_outputs("step");
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return ADDR_W'($urandom_range(0, 15));
        return ADDR_W'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic rnd_step(input logic st);
        step(st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(),
             DATA_W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             rnd_addr(), DATA_W'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        init_start = 0; en_a = 0; we_a = 0; en_b = 0; we_b = 0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
        model_reset();
        #1;
        check_outputs("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_hold");
        rst_n = 1'b1;
    endtask

    // Start cycle carries a user write and a cross-port read of the same address.
    task automatic run_seed(input int abort_at);
        int cnt;
        cnt = 0;
        step(1'b1, 1'b1, 1'b1, 12'h010, 13'h0777, 1'b1, 1'b0, 12'h010, '0);
        while (init_busy && cnt < 5000) begin
            if (abort_at >= 0 && cnt == abort_at) break;
            cnt++;
            rnd_step(cnt == 50);
        end
        if (abort_at < 0) check("seed_len", cnt, SEED_CYC);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i += 2)
            step(1'b0, 1'b1, 1'b0, ADDR_W'(i), '0, 1'b1, 1'b0, ADDR_W'(i + 1), '0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic              ea, wa;
        logic [ADDR_W-1:0] aa;
        logic [DATA_W-1:0] da;
        logic              eb, wb;
        logic [ADDR_W-1:0] ab;
        logic [DATA_W-1:0] db;
        logic              xva;
        logic [DATA_W-1:0] xda;
        logic              xvb;
        logic [DATA_W-1:0] xdb;
        logic              xcol;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ea, input logic wa, input logic [ADDR_W-1:0] aa,
                                input logic [DATA_W-1:0] da, input logic eb, input logic wb,
                                input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db,
                                input logic xva, input logic [DATA_W-1:0] xda,
                                input logic xvb, input logic [DATA_W-1:0] xdb, input logic xcol);
        vec_t v;
        v.ea = ea; v.wa = wa; v.aa = aa; v.da = da;
        v.eb = eb; v.wb = wb; v.ab = ab; v.db = db;
        v.xva = xva; v.xda = xda; v.xvb = xvb; v.xdb = xdb; v.xcol = xcol;
        return v;
    endfunction

    initial begin
        rst_n = 1'b1;
        init_start = 0; en_a = 0; we_a = 0; en_b = 0; we_b = 0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // Held values entering the table are 0x1FFF on both ports (last read_all pair).
        tbl.push_back(mk(1,0,12'h005,0,     0,0,12'h000,0,      1,13'h0005, 0,13'h1FFF, 0));
        tbl.push_back(mk(1,0,12'h0FF,0,     1,0,12'h100,0,      1,13'h00FF, 1,13'h1FFF, 0));
        tbl.push_back(mk(1,0,12'hFFF,0,     0,0,12'h000,0,      1,13'h1FFF, 0,13'h1FFF, 0));
        tbl.push_back(mk(1,1,12'h123,13'h0ABC, 0,0,12'h000,0,   0,13'h1FFF, 0,13'h1FFF, 0));
        tbl.push_back(mk(0,0,12'h000,0,     1,0,12'h123,0,      0,13'h1FFF, 1,13'h0ABC, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,12'h000,0, 0,0,12'h000,0,      0,13'h1FFF, 0,13'h0ABC, 0));
        tbl.push_back(mk(1,1,12'h200,13'h0111, 1,1,12'h200,13'h0222, 0,13'h1FFF, 0,13'h0ABC, 1));
        tbl.push_back(mk(1,0,12'h200,0,     0,0,12'h000,0,      1,13'h0222, 0,13'h0ABC, 0));
        tbl.push_back(mk(1,0,12'h301,0,     1,1,12'h301,13'h0042, 1,13'h1FFF, 0,13'h0ABC, 0));
        tbl.push_back(mk(1,0,12'h301,0,     0,0,12'h000,0,      1,13'h0042, 0,13'h0ABC, 0));
        for (int i = 4; i < 8; i++)
            tbl.push_back(mk(1,0,ADDR_W'(i),0, 0,0,12'h000,0,   1,DATA_W'(i), 0,13'h0ABC, 0));
        tbl.push_back(mk(1,0,12'h204,0,     1,1,12'h208,13'h0055, 1,13'h1FFF, 0,13'h0ABC, 0));
        tbl.push_back(mk(1,0,12'h204,0,     1,0,12'h208,0,      1,13'h1FFF, 1,13'h0055, 0));

        #2;
        do_reset();
        @(posedge clk);
        #1;
        check_outputs("idle");

        run_seed(-1);
        check("done_after_seed", init_done, 1'b1);
        read_all();

        foreach (tbl[k]) begin
            step(1'b0, tbl[k].ea, tbl[k].wa, tbl[k].aa, tbl[k].da,
                 tbl[k].eb, tbl[k].wb, tbl[k].ab, tbl[k].db);
            check($sformatf("tbl%0d_rvalid_a", k), rvalid_a, tbl[k].xva);
            check($sformatf("tbl%0d_rdata_a", k),  rdata_a,  tbl[k].xda);
            check($sformatf("tbl%0d_rvalid_b", k), rvalid_b, tbl[k].xvb);
            check($sformatf("tbl%0d_rdata_b", k),  rdata_b,  tbl[k].xdb);
            check($sformatf("tbl%0d_collision", k), collision, tbl[k].xcol);
        end

        for (int i = 0; i < 1500; i++) rnd_step(1'b0);

        // Restart from DONE, abort mid-seed with reset, then seed again from IDLE.
        run_seed(100);
        do_reset();
        run_seed(-1);
        check("done_after_reseed", init_done, 1'b1);
        read_all();
        for (int i = 0; i < 300; i++) rnd_step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
